// File: rtl/sqrt_share_pkg.sv
// Shared types and the round-robin pick helper for the square-root pipeline arbiter.
package sqrt_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW      = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;
  localparam int MAXREQ   = 32;

  typedef logic [IDW-1:0] id_t;

  typedef enum logic {ARB, LOCK} arb_st_e;

  // First set bit of valid scanning upward from ptr+1 with wrap; falls back to ptr.
  function automatic int rr_pick(input logic [MAXREQ-1:0] valid, input int ptr, input int nreq);
    int  idx;
    int  pick;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAXREQ; k++) begin
      idx = (ptr + k) % nreq;
      if (!found && (k <= nreq) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sqrt_tag_fifo.sv
// In-order requester-id FIFO: register array with a combinational head output.
module sqrt_tag_fifo #(
  parameter int TDEP = 8,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [IDW-1:0] din,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output logic [IDW-1:0] dout
);

  localparam int AW = $clog2(TDEP);

  logic [IDW-1:0] mem [TDEP];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign full    = (count == (AW+1)'(TDEP));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_share_arb.sv
// Packet-level round-robin sharing of one streaming sqrt pipeline among NREQ clients.
// Optional per-requester result counters under SQRT_SHARE_ARB_STAT_EN.
module sqrt_share_arb
  import sqrt_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int RDW  = 4,
  parameter int TDEP = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0][2*RDW-1:0]   req_num,
  input  logic [NREQ-1:0]              req_last,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  output logic [RDW-1:0]               res_sqrt,
  output logic [2*RDW-1:0]             res_rem,
  output logic                         res_last,
  output logic [NREQ-1:0]              res_valid,
  input  logic [NREQ-1:0]              res_ready,
  output logic [2*RDW-1:0]             sq_num,
  output logic                         sq_ilast,
  output logic                         sq_ivalid,
  input  logic                         sq_iready,
  input  logic [RDW-1:0]               sq_sqrt,
  input  logic [2*RDW-1:0]             sq_rem,
  input  logic                         sq_olast,
  input  logic                         sq_ovalid,
  output logic                         sq_oready
`ifdef SQRT_SHARE_ARB_STAT_EN
  ,
  input  logic                         cnt_clr,
  output logic [NREQ-1:0][15:0]        item_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_st_e       state, state_n;
  logic [IW-1:0] lk, lk_n, rr_ptr, rr_n, gnt, head;
  logic          tag_full, tag_empty, issue, pop;

  // Issue side: every handshake qualifier is masked by rst so nothing moves during reset.
  always_comb begin
    gnt       = (state == LOCK) ? lk : IW'(rr_pick(MAXREQ'(req_valid), int'(rr_ptr), NREQ));
    sq_num    = req_num[gnt];
    sq_ilast  = req_last[gnt];
    sq_ivalid = ~rst & ~tag_full & ((state == LOCK) ? req_valid[lk] : |req_valid);
    req_ready = '0;
    req_ready[gnt] = ~rst & sq_iready & ~tag_full;
  end

  assign issue = sq_ivalid & sq_iready;

  always_comb begin
    res_valid       = '0;
    res_valid[head] = ~rst & sq_ovalid & ~tag_empty;
    sq_oready       = ~rst & res_ready[head] & ~tag_empty;
  end

  assign pop      = sq_ovalid & sq_oready;
  assign res_sqrt = sq_sqrt;
  assign res_rem  = sq_rem;
  assign res_last = sq_olast;

  sqrt_tag_fifo #(.TDEP(TDEP), .IDW(IW)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (gnt),
    .pop   (pop),
    .full  (tag_full),
    .empty (tag_empty),
    .dout  (head)
  );

  // Lock is released only by a last handshake; priority rotates to the finishing requester.
  always_comb begin
    state_n = state;
    lk_n    = lk;
    rr_n    = rr_ptr;
    if (issue) begin
      if (req_last[gnt]) begin
        state_n = ARB;
        rr_n    = gnt;
      end else begin
        state_n = LOCK;
        lk_n    = gnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB;
      lk     <= '0;
      rr_ptr <= IW'(NREQ-1);
    end else begin
      state  <= state_n;
      lk     <= lk_n;
      rr_ptr <= rr_n;
    end
  end

  a_no_orphan_result: assert property (@(posedge clk) disable iff (rst) !(sq_ovalid && tag_empty));

`ifdef SQRT_SHARE_ARB_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          item_cnt <= '0;
    else if (cnt_clr) item_cnt <= '0;
    else if (pop)     item_cnt[head] <= item_cnt[head] + 16'd1;
  end
`endif

endmodule

// File: doc/sqrt_share_arb.md
Name: sqrt_share_arb

Overview:
- Shares one streaming square-root pipeline (2*RDW-bit radicand in; RDW-bit root and 2*RDW-bit remainder out; valid/ready/last handshakes) among NREQ requesters.
- Arbitrates round-robin at packet granularity; a packet is delimited by last.
- Tags each issued item with its requester id in an in-order tag FIFO.
- Steers each result back to the owning requester.
- Sits between client streams and the external pipeline instance, which it neither contains nor modifies.

Parameters:
- NREQ, 4, number of requesters (≥2).
- RDW, 4, root width; radicand/remainder width is 2*RDW.
- TDEP, 8, tag FIFO depth; power of 2 and ≥ RDW+1, so the FIFO is never the throughput limit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_num  in  NREQ x 2*RDW  per-requester radicand.
- req_last  in  NREQ  per-requester packet end.
- req_valid  in  NREQ  per-requester valid.
- req_ready  out  NREQ  per-requester ready.
- res_sqrt  out  RDW  result root, shared by all requesters.
- res_rem  out  2*RDW  result remainder, shared.
- res_last  out  1  result last, shared.
- res_valid  out  NREQ  per-requester result valid; one-hot or zero.
- res_ready  in  NREQ  per-requester result ready.
- sq_num  out  2*RDW  to pipeline: radicand.
- sq_ilast  out  1  to pipeline: last.
- sq_ivalid  out  1  to pipeline: valid.
- sq_iready  in  1  from pipeline: ready.
- sq_sqrt  in  RDW  from pipeline: root.
- sq_rem  in  2*RDW  from pipeline: remainder.
- sq_olast  in  1  from pipeline: last.
- sq_ovalid  in  1  from pipeline: valid.
- sq_oready  out  1  to pipeline: ready.

Behaviour:
- Reset (async): FSM=ARB, rr_ptr=NREQ-1 (requester 0 has first priority), tag FIFO empty (count=0, rd/wr pointers 0).
  - Consequence: req_ready=0, sq_ivalid=0, res_valid=0, sq_oready=0 while rst is high and on release.
- FSM state ARB:
  - gnt = first requester with req_valid set, scanning from rr_ptr+1 upward with wrap.
  - sq_ivalid = any req_valid & ~tag_full.
- FSM state LOCK(lk):
  - gnt = lk only; sq_ivalid = req_valid[lk] & ~tag_full.
  - Other requesters are held (req_ready=0) even if valid.
- Issue path:
  - sq_num/sq_ilast = req_num/req_last of gnt.
  - req_ready[gnt] = sq_iready & ~tag_full; all other req_ready = 0.
  - Zero-latency combinational path; no input register.
- Issue handshake (sq_ivalid & sq_iready):
  - Push gnt id into the tag FIFO.
  - If req_last[gnt]=0: enter LOCK(gnt).
  - If req_last[gnt]=1: go to (or stay in) ARB and set rr_ptr=gnt.
- Single-item packets (last=1) therefore rotate priority every item.
- Result path:
  - head = tag FIFO read data.
  - res_valid[head] = sq_ovalid & ~tag_empty; all other res_valid = 0.
  - sq_oready = res_ready[head] & ~tag_empty.
  - res_sqrt/res_rem/res_last pass through from the pipeline.
- Result handshake (sq_ovalid & sq_oready): pop the tag FIFO.
- Tag FIFO count update: push-only +1; pop-only -1; simultaneous push and pop leaves count unchanged.
- Full FIFO: push is blocked (tag_full=1) even if a pop happens in the same cycle; there is no full-bypass.
- Empty FIFO with sq_ovalid=1 is a protocol error.
  - Block drives sq_oready=0 and res_valid=0.
  - Simulation assertion fires.
- A requester dropping req_valid mid-packet keeps the lock; lock releases only on a last handshake.
- Pipeline backpressure (sq_iready=0): gnt and the lock are held; no rr_ptr change.

Optional Feature:
- Macro: SQRT_SHARE_ARB_STAT_EN.
- With the macro:
  - Adds output port item_cnt (NREQ x 16): per-requester count of result handshakes.
  - Adds input port cnt_clr (1): synchronous clear of all counters; clear wins over a same-cycle increment.
  - Counters wrap at 16'hFFFF→0 and reset to 0.
- Without the macro: neither port nor counter logic exists.

Decomposition:
- Package sqrt_share_pkg:
  - IDW = NREQ>1 ? $clog2(NREQ) : 1.
  - Typedef id_t (IDW bits).
  - Enum arb_st_e {ARB, LOCK}.
  - Helper function rr_pick(valid vector, ptr) returning the next grant.
- Sub-module sqrt_tag_fifo: synchronous-read-free FIFO (register array, combinational head output), with params TDEP and IDW, ports push/pop/full/empty/dout, async reset.

Test Plan:
- Reset, then drive 1 item, req_valid[0] with num=8'd49, last=1, behind a real pipeline at RDW=4 → res_valid[0] after the pipeline latency (RDW=4 stages), sqrt=7, rem=0; other res_valid stay 0.
- All 4 requesters continuously valid with single-item packets; req n sends num=n*10+5 → issue order 0,1,2,3,0,…; results routed back in order; req 2 gets num=25 → sqrt=5, rem=0.
- Req 1 sends a 3-item packet (num 2,3,4) while req 0 and req 3 are valid → the 3 items issue back-to-back uninterrupted; then grant passes to 2/3/0 per rr_ptr=1; results sqrt 1,1,2 with rem 1,2,0 on req 1.
- Hold res_ready[2]=0 while req 2's results are at the FIFO head → sq_oready=0; the pipeline fills; once TDEP items are in flight, tag_full forces all req_ready=0; releasing res_ready drains in order with no loss.
- Assert rst mid-packet while LOCK(3) with 5 items in flight → all outputs 0 immediately; after release, req 0 has priority and the FIFO count is 0.
- With SQRT_SHARE_ARB_STAT_EN: 10 results to req 1 → item_cnt[1]=10; cnt_clr in the same cycle as an increment → 0.
